id_ex_stage: RTL and testbench

- ID/EX pipeline register that sits directly upstream of the 32-bit ALU and produces its `op`, `A` and `B` each cycle.
- Registers decoded-instruction fields and generates the 4-bit ALU op from ALUOp/funct.
- Selects the immediate or register for `B`, and forwards results from EX/MEM and MEM/WB into the operands.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

---
 rtl/id_ex_stage.sv | 105 ++++++++++
 tb/tb_id_ex_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with ALU op decode, immediate select and EX/MEM, MEM/WB forwarding (ID_EX_NOR_EN adds nor decode)
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [1:0]    aluop,
  input  logic [5:0]    funct,
  input  logic [DW-1:0] rs_data,
  input  logic [DW-1:0] rt_data,
  input  logic [15:0]   imm,
  input  logic          alusrc,
  input  logic          sign_ext,
  input  logic [RW-1:0] rs_addr,
  input  logic [RW-1:0] rt_addr,
  input  logic [RW-1:0] rd_addr,
  input  logic          regdst,
  input  logic          regwrite,
  input  logic          exmem_wr,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_res,
  input  logic          memwb_wr,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_res,
  output logic [3:0]    op,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic [DW-1:0] store_data,
  output logic [RW-1:0] wr_addr,
  output logic          wr_en,
  output logic          out_valid,
  output logic          illegal
);
  logic [3:0]    dec_op, op_q;
  logic          dec_ill, ill_q, v_q, wen_q, src_q;
  logic [RW-1:0] wa_q, rsa_q, rta_q;
  logic [DW-1:0] rsd_q, rtd_q, ext_q, imm_ext, fwd_rs, fwd_rt;
  logic          bubble, load;
  assign bubble  = flush | ~in_valid;
  assign load    = flush | ~stall;
  assign imm_ext = sign_ext ? {{(DW-16){imm[15]}}, imm} : {{(DW-16){1'b0}}, imm};
  // ALU op decode from aluop/funct; unknown R-type funct falls back to add and flags illegal
  always_comb begin
    dec_op  = 4'b0010;
    dec_ill = 1'b0;
    if (aluop == 2'b01) dec_op = 4'b0110;
    else if (aluop == 2'b11) dec_op = 4'b0001;
    else if (aluop == 2'b10)
      case (funct)
        6'b100000: dec_op = 4'b0010;
        6'b100010: dec_op = 4'b0110;
        6'b100100: dec_op = 4'b0000;
        6'b100101: dec_op = 4'b0001;
        6'b101010: dec_op = 4'b0111;
`ifdef ID_EX_NOR_EN
        6'b100111: dec_op = 4'b1100;
`endif
        default:   dec_ill = 1'b1;
      endcase
  end
  // stage register: flush or an empty ID slot loads a bubble, stall holds, otherwise capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= 1'b0;
      wen_q <= 1'b0;
      op_q  <= 4'b0010;
      ill_q <= 1'b0;
      wa_q  <= '0;
      rsa_q <= '0;
      rta_q <= '0;
      rsd_q <= '0;
      rtd_q <= '0;
      ext_q <= '0;
      src_q <= 1'b0;
    end else if (load) begin
      v_q   <= ~bubble;
      wen_q <= ~bubble & regwrite;
      op_q  <= bubble ? 4'b0010 : dec_op;
      ill_q <= ~bubble & dec_ill;
      wa_q  <= bubble ? '0 : (regdst ? rd_addr : rt_addr);
      rsa_q <= bubble ? '0 : rs_addr;
      rta_q <= bubble ? '0 : rt_addr;
      rsd_q <= bubble ? '0 : rs_data;
      rtd_q <= bubble ? '0 : rt_data;
      ext_q <= bubble ? '0 : imm_ext;
      src_q <= ~bubble & alusrc;
    end
  end
  assign fwd_rs = (exmem_wr && exmem_rd != '0 && exmem_rd == rsa_q) ? exmem_res :
                  (memwb_wr && memwb_rd != '0 && memwb_rd == rsa_q) ? memwb_res : rsd_q;
  assign fwd_rt = (exmem_wr && exmem_rd != '0 && exmem_rd == rta_q) ? exmem_res :
                  (memwb_wr && memwb_rd != '0 && memwb_rd == rta_q) ? memwb_res : rtd_q;
  assign op         = op_q;
  assign A          = fwd_rs;
  assign store_data = fwd_rt;
  assign B          = src_q ? ext_q : fwd_rt;
  assign wr_addr    = wa_q;
  assign wr_en      = wen_q;
  assign out_valid  = v_q;
  assign illegal    = ill_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized and directed checks of id_ex_stage against a behavioural model
module tb_id_ex_stage;
  logic        clk = 1'b0, rst = 1'b0, stall, flush, in_valid;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [31:0] rs_data, rt_data, exmem_res, memwb_res;
  logic [15:0] imm;
  logic        alusrc, sign_ext, regdst, regwrite, exmem_wr, memwb_wr;
  logic [4:0]  rs_addr, rt_addr, rd_addr, exmem_rd, memwb_rd;
  logic [3:0]  op;
  logic [31:0] A, B, store_data;
  logic [4:0]  wr_addr;
  logic        wr_en, out_valid, illegal;
  int n_tests = 0, n_fail = 0;
  typedef struct {
    logic v, wen, ill, src;
    logic [3:0] op;
    logic [4:0] wa, rsa, rta;
    logic [31:0] rsd, rtd, ext;
  } instr_t;
  instr_t m;
  logic lit_en = 1'b0, l_wen, l_ov, l_ill;
  logic [3:0] l_op;
  logic [31:0] l_a, l_b, l_sd, ea, eb, es;
  logic [4:0] l_wa;
  logic [5:0] ftab [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27};

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .aluop(aluop), .funct(funct), .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
    .alusrc(alusrc), .sign_ext(sign_ext), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rd_addr(rd_addr), .regdst(regdst), .regwrite(regwrite),
    .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_res(exmem_res),
    .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_res(memwb_res),
    .op(op), .A(A), .B(B), .store_data(store_data), .wr_addr(wr_addr),
    .wr_en(wr_en), .out_valid(out_valid), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic instr_t bubble_instr();
    instr_t b;
    b = '{v: 1'b0, wen: 1'b0, ill: 1'b0, src: 1'b0, op: 4'b0010, wa: 5'd0, rsa: 5'd0, rta: 5'd0,
          rsd: 32'd0, rtd: 32'd0, ext: 32'd0};
    return b;
  endfunction

  function automatic logic [4:0] decode(input logic [1:0] a, input logic [5:0] f);
    if (a == 2'b00) return {4'd2, 1'b0};
    if (a == 2'b01) return {4'd6, 1'b0};
    if (a == 2'b11) return {4'd1, 1'b0};
    case (f)
      6'h20: return {4'd2, 1'b0};
      6'h22: return {4'd6, 1'b0};
      6'h24: return {4'd0, 1'b0};
      6'h25: return {4'd1, 1'b0};
      6'h2a: return {4'd7, 1'b0};
`ifdef ID_EX_NOR_EN
      6'h27: return {4'd12, 1'b0};
`endif
      default: return {4'd2, 1'b1};
    endcase
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
    if (a == 0) return d;
    if (exmem_wr && exmem_rd == a) return exmem_res;
    if (memwb_wr && memwb_rd == a) return memwb_res;
    return d;
  endfunction

  // model of the instruction held in EX
  always @(posedge clk or posedge rst) begin
    if (rst) m = bubble_instr();
    else if (flush || (!stall && !in_valid)) m = bubble_instr();
    else if (!stall) begin
      m.v   = 1'b1;
      m.wen = regwrite;
      {m.op, m.ill} = decode(aluop, funct);
      m.wa  = regdst ? rd_addr : rt_addr;
      m.rsa = rs_addr;
      m.rta = rt_addr;
      m.rsd = rs_data;
      m.rtd = rt_data;
      m.ext = sign_ext ? 32'($signed(imm)) : 32'(imm);
      m.src = alusrc;
    end
  end

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // compare process: DUT against model every cycle, plus literal expectations when armed
  always @(negedge clk) begin
    ea = fwd(m.rsa, m.rsd);
    es = fwd(m.rta, m.rtd);
    eb = m.src ? m.ext : es;
    cmp("op", 32'(op), 32'(m.op));
    cmp("A", A, ea);
    cmp("B", B, eb);
    cmp("store_data", store_data, es);
    cmp("wr_addr", 32'(wr_addr), 32'(m.wa));
    cmp("wr_en", 32'(wr_en), 32'(m.wen));
    cmp("out_valid", 32'(out_valid), 32'(m.v));
    cmp("illegal", 32'(illegal), 32'(m.ill));
    if (lit_en) begin
      cmp("lit_op", 32'(op), 32'(l_op));
      cmp("lit_A", A, l_a);
      cmp("lit_B", B, l_b);
      cmp("lit_store_data", store_data, l_sd);
      cmp("lit_wr_addr", 32'(wr_addr), 32'(l_wa));
      cmp("lit_wr_en", 32'(wr_en), 32'(l_wen));
      cmp("lit_out_valid", 32'(out_valid), 32'(l_ov));
      cmp("lit_illegal", 32'(illegal), 32'(l_ill));
    end
  end

  task automatic set_id(input logic [1:0] a, input logic [5:0] f, input logic [31:0] rsd, rtd,
                        input logic [15:0] im, input logic src, sx, input logic [4:0] rsa, rta, rda,
                        input logic rdst, rw, iv);
    aluop = a; funct = f; rs_data = rsd; rt_data = rtd; imm = im; alusrc = src; sign_ext = sx;
    rs_addr = rsa; rt_addr = rta; rd_addr = rda; regdst = rdst; regwrite = rw; in_valid = iv;
  endtask

  task automatic prod(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                      input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
    exmem_wr = ew; exmem_rd = erd; exmem_res = eres; memwb_wr = mw; memwb_rd = mrd; memwb_res = mres;
  endtask

  task automatic rand_id();
    aluop = 2'($urandom); funct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ftab[$urandom_range(0, 5)];
    rs_data = $urandom; rt_data = $urandom; imm = 16'($urandom); alusrc = 1'($urandom);
    sign_ext = 1'($urandom); rs_addr = 5'($urandom_range(0, 7)); rt_addr = 5'($urandom_range(0, 7));
    rd_addr = 5'($urandom_range(0, 7)); regdst = 1'($urandom); regwrite = 1'($urandom);
    in_valid = $urandom_range(0, 4) != 0;
  endtask

  task automatic expect_all(input logic [3:0] eo, input logic [31:0] a, b, sd, input logic [4:0] wa,
                            input logic wen, ov, ill);
    l_op = eo; l_a = a; l_b = b; l_sd = sd; l_wa = wa; l_wen = wen; l_ov = ov; l_ill = ill;
    lit_en = 1'b1;
    @(negedge clk);
    #1 lit_en = 1'b0;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] sw_a [8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b00};
  logic [5:0] sw_f [8] = '{6'h22, 6'h24, 6'h25, 6'h2a, 6'h07, 6'h07, 6'h3f, 6'h2a};
  logic [3:0] sw_o [8] = '{4'd6, 4'd0, 4'd1, 4'd7, 4'd2, 4'd6, 4'd1, 4'd2};
  logic       sw_i [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    stall = 0; flush = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    prod(0, 0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    expect_all(4'd2, 0, 0, 0, 0, 0, 0, 0);
    set_id(2'b10, 6'h20, 25, 75, 0, 0, 0, 1, 2, 3, 1, 1, 1);
    edge1();
    expect_all(4'd2, 25, 75, 75, 3, 1, 1, 0);
    edge1();
    #1 rst = 1'b1;
    expect_all(4'd2, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_id(sw_a[i], sw_f[i], 25, 75, 0, 0, 0, 1, 2, 3, 1, 1, 1);
      edge1();
      expect_all(sw_o[i], 25, 75, 75, 3, 1, 1, sw_i[i]);
    end
    set_id(2'b00, 6'h0, 7, 9, 0, 0, 0, 4, 5, 6, 0, 1, 1);
    edge1();
    prod(1, 4, 100, 1, 4, 200);
    expect_all(4'd2, 100, 9, 9, 5, 1, 1, 0);
    prod(0, 4, 100, 1, 4, 200);
    expect_all(4'd2, 200, 9, 9, 5, 1, 1, 0);
    prod(1, 0, 100, 1, 0, 200);
    expect_all(4'd2, 7, 9, 9, 5, 1, 1, 0);
    prod(0, 0, 0, 1, 5, 300);
    expect_all(4'd2, 7, 300, 300, 5, 1, 1, 0);
    prod(0, 0, 0, 0, 0, 0);
    set_id(2'b00, 6'h0, 25, 75, 16'hFFFF, 1, 1, 1, 2, 3, 0, 1, 1);
    edge1();
    expect_all(4'd2, 25, 32'hFFFFFFFF, 75, 2, 1, 1, 0);
    sign_ext = 0;
    edge1();
    expect_all(4'd2, 25, 32'h0000FFFF, 75, 2, 1, 1, 0);
    set_id(2'b10, 6'h20, 25, 75, 0, 0, 0, 1, 2, 3, 1, 1, 0);
    edge1();
    expect_all(4'd2, 0, 0, 0, 0, 0, 0, 0);
    set_id(2'b10, 6'h20, 25, 75, 0, 0, 0, 1, 2, 3, 1, 1, 1);
    edge1();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      edge1();
      expect_all(4'd2, 25, 75, 75, 3, 1, 1, 0);
    end
    flush = 1; in_valid = 1;
    edge1();
    expect_all(4'd2, 0, 0, 0, 0, 0, 0, 0);
    stall = 0; flush = 0;
    for (int i = 0; i < 400; i++) begin
      rand_id();
      stall = $urandom_range(0, 3) == 0;
      flush = $urandom_range(0, 9) == 0;
      rst = $urandom_range(0, 99) == 0;
      prod(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      edge1();
    end
    rst = 0;
    @(negedge clk);
    #1 $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
